uart_rx_word_controller: RTL and testbench

Read-side sequencer for the UART receive FIFO. It drains bytes from the FIFO (`dout`/`empty`/`re`) and assembles `BYTES_PER_WORD` consecutive bytes, little-endian, into one word. The word is presented on a valid/ready handshake to the core-side consumer, such as a loader or MMIO register. An inter-byte timeout discards partially assembled words so a truncated transfer cannot desynchronise the stream.

---
 rtl/uart_rx_word_controller.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_word_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word_controller.sv
// ---------------------------------------------------------------------------
// uart_rx_word_controller
//
// Read-side sequencer for the UART receive FIFO. Bytes are drained from the
// FIFO and packed little-endian into a word of BYTES_PER_WORD bytes. The word
// is offered to the consumer on a valid/ready handshake. If the line goes
// quiet in the middle of a word for longer than TIMEOUT_BYTES character
// times, the partial word is dropped and timeout_err pulses for one cycle.
// Dropping the partial word keeps later words aligned to byte 0.
//
// Ports
//   clk          : single clock
//   rst          : asynchronous, active-high reset
//   fifo_dout    : FIFO read data, valid the cycle after fifo_re
//   fifo_empty   : FIFO empty flag
//   fifo_re      : FIFO read enable (never asserted while fifo_empty)
//   word         : assembled word, byte 0 in [7:0]
//   word_valid   : word is available, held until word_ready
//   word_ready   : consumer accepts word
//   timeout_err  : one-cycle pulse when a partial word is discarded
//   busy         : partial word held or word_valid high
// ---------------------------------------------------------------------------
module uart_rx_word_controller #(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter logic [31:0] BYTES_PER_WORD  = 32'd4,
    parameter logic [31:0] TIMEOUT_BYTES   = 32'd4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    fifo_dout,
    input  logic                          fifo_empty,
    output logic                          fifo_re,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          timeout_err,
    output logic                          busy
);

    // 10 bit times per character (start + 8 data + stop).
    localparam logic [31:0] TIMEOUT_CYCLES =
        TIMEOUT_BYTES * 32'd10 * (CLOCK_FREQUENCY / BAUD_RATE);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    // A single-byte word still needs a 1-bit index register.
    localparam int IDX_W = (BYTES_PER_WORD > 32'd1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 32'd1);
    localparam int NUM_LANES = int'(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        CAPTURE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;

    logic [IDX_W-1:0]              r_idx;
    logic [31:0]                   r_cnt;
    logic [8*BYTES_PER_WORD-1:0]   r_word;
    logic                          r_word_valid;
    logic                          r_timeout_err;

    // Decoded per-cycle events, produced by the output process.
    logic                          w_fifo_re;
    logic                          w_idle_wait;
    logic                          w_timeout_hit;
    logic                          w_last_byte;
    logic                          w_handshake;

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH: begin
                // A timeout keeps the FSM in FETCH; only a read leaves it.
                if (!fifo_empty) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (r_idx == LAST_IDX) begin
                    w_next_state = OUTPUT;
                end else begin
                    w_next_state = FETCH;
                end
            end
            OUTPUT: begin
                if (r_word_valid && word_ready) begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: output / event decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_fifo_re     = 1'b0;
        w_idle_wait   = 1'b0;
        w_timeout_hit = 1'b0;
        w_last_byte   = 1'b0;
        w_handshake   = 1'b0;
        case (r_state)
            FETCH: begin
                w_fifo_re = !fifo_empty;
                // Counting only while a partial word is held; a pending read
                // takes priority over a terminal count in the same cycle.
                w_idle_wait   = fifo_empty && (r_idx != '0);
                w_timeout_hit = w_idle_wait && (r_cnt == TIMEOUT_LAST);
            end
            CAPTURE: begin
                w_last_byte = (r_idx == LAST_IDX);
            end
            OUTPUT: begin
                w_handshake = r_word_valid && word_ready;
            end
            default: begin
                w_fifo_re = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Byte index and inter-byte timeout counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (!fifo_empty) begin
                        r_cnt <= '0;
                    end else if (w_idle_wait) begin
                        if (w_timeout_hit) begin
                            r_idx         <= '0;
                            r_cnt         <= '0;
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    if (w_last_byte) begin
                        r_idx <= '0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Word register and valid flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            if (r_state == CAPTURE) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        r_word[i*8 +: 8] <= fifo_dout;
                    end
                end
                if (w_last_byte) begin
                    r_word_valid <= 1'b1;
                end
            end else if (w_handshake) begin
                // Clearing the word means stale lanes never leak into the
                // next word if it is later truncated by a timeout.
                r_word       <= '0;
                r_word_valid <= 1'b0;
            end
        end
    end

    assign fifo_re     = w_fifo_re;
    assign word        = r_word;
    assign word_valid  = r_word_valid;
    assign timeout_err = r_timeout_err;
    // Derived from registers only, so no combinational input-to-output path.
    assign busy        = (r_idx != '0) || r_word_valid;

endmodule

// File: tb/tb_uart_rx_word_controller.sv
module tb_uart_rx_word_controller;

    localparam logic [31:0] CLK_HZ = 32'd1_000_000;
    localparam logic [31:0] BAUD   = 32'd100_000;
    localparam logic [31:0] BPW    = 32'd4;
    localparam logic [31:0] TO_B   = 32'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_re;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;
    logic        timeout_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_word_controller #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .BAUD_RATE       (BAUD),
        .BYTES_PER_WORD  (BPW),
        .TIMEOUT_BYTES   (TO_B)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_re     (fifo_re),
        .word        (word),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // FIFO model, 1-cycle read latency. Stimulus owns wr_ptr, model owns rd_ptr.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_re) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // Protocol monitor: counts events over the cycle ending at each edge.
    int          re_cnt       = 0;
    int          adj_cnt      = 0;
    int          bad_re_cnt   = 0;
    int          valid_cyc    = 0;
    int          unstable_cnt = 0;
    int          to_cnt       = 0;
    int          busy_cyc     = 0;
    logic        prev_re      = 1'b0;
    logic        prev_valid   = 1'b0;
    logic [31:0] prev_word    = 32'd0;

    always @(posedge clk) begin
        if (fifo_re) re_cnt <= re_cnt + 1;
        if (fifo_re && prev_re) adj_cnt <= adj_cnt + 1;
        if (fifo_re && fifo_empty) bad_re_cnt <= bad_re_cnt + 1;
        if (word_valid) valid_cyc <= valid_cyc + 1;
        if (word_valid && prev_valid && (word != prev_word)) unstable_cnt <= unstable_cnt + 1;
        if (timeout_err) to_cnt <= to_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        prev_re    <= fifo_re;
        prev_valid <= word_valid;
        prev_word  <= word;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!word_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 64'(word_valid), 64'd1);
    endtask

    int s_re, s_valid, s_to, s_busy;

    initial begin
        rst        = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        check_val("rst_fifo_re", 64'(fifo_re), 64'd0);
        check_val("rst_word", 64'(word), 64'd0);
        check_val("rst_valid", 64'(word_valid), 64'd0);
        check_val("rst_timeout", 64'(timeout_err), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick(2);

        // 1: basic assembly with an always-ready consumer
        s_re    = re_cnt;
        s_valid = valid_cyc;
        push(8'h78); push(8'h56); push(8'h34); push(8'h12);
        wait_valid("t1_valid_rise", 40);
        check_val("t1_word", 64'(word), 64'h12345678);
        tick(1);
        check_val("t1_valid_fall", 64'(word_valid), 64'd0);
        tick(2);
        check_val("t1_re_pulses", 64'(re_cnt - s_re), 64'd4);
        check_val("t1_valid_cycles", 64'(valid_cyc - s_valid), 64'd1);
        check_val("t1_adjacent_re", 64'(adj_cnt), 64'd0);

        // 2: backpressure holds the first word, FIFO absorbs the rest
        word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_valid("t2_valid1", 40);
        check_val("t2_word1", 64'(word), 64'h04030201);
        s_re = re_cnt;
        tick(50);
        check_val("t2_word1_held", 64'(word), 64'h04030201);
        check_val("t2_valid_held", 64'(word_valid), 64'd1);
        check_val("t2_no_re", 64'(re_cnt - s_re), 64'd0);
        check_val("t2_busy", 64'(busy), 64'd1);
        word_ready = 1'b1;
        tick(1);
        check_val("t2_handshake", 64'(word_valid), 64'd0);
        wait_valid("t2_valid2", 40);
        check_val("t2_word2", 64'(word), 64'h08070605);
        tick(3);

        // 3: timeout after two bytes. Reads at edges 1,3; captures at 2,4;
        // counter hits 199 after edge 203, pulse visible after edge 204.
        s_to = to_cnt;
        push(8'hAA); push(8'hBB);
        tick(203);
        check_val("t3_no_early_to", 64'(timeout_err), 64'd0);
        check_val("t3_busy_before", 64'(busy), 64'd1);
        tick(1);
        check_val("t3_to_pulse", 64'(timeout_err), 64'd1);
        check_val("t3_busy_after", 64'(busy), 64'd0);
        tick(1);
        check_val("t3_to_one_cycle", 64'(timeout_err), 64'd0);
        check_val("t3_to_count", 64'(to_cnt - s_to), 64'd1);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_valid("t3_valid", 40);
        check_val("t3_word", 64'(word), 64'h44332211);
        tick(3);

        // 4: byte arrives in the cycle the counter sits at 199 (read wins)
        s_to = to_cnt;
        push(8'h5A);
        tick(201);
        check_val("t4_busy", 64'(busy), 64'd1);
        push(8'h6B);
        tick(3);
        push(8'h7C); push(8'h8D);
        wait_valid("t4_valid", 40);
        check_val("t4_word", 64'(word), 64'h8D7C6B5A);
        check_val("t4_no_timeout", 64'(to_cnt - s_to), 64'd0);
        tick(3);

        // 5: asynchronous reset in the middle of a word
        push(8'h11); push(8'h22);
        tick(6);
        check_val("t5_partial", 64'(word), 64'h00002211);
        check_val("t5_busy_pre", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_val("t5_rst_word", 64'(word), 64'd0);
        check_val("t5_rst_valid", 64'(word_valid), 64'd0);
        check_val("t5_rst_busy", 64'(busy), 64'd0);
        check_val("t5_rst_to", 64'(timeout_err), 64'd0);
        check_val("t5_rst_re", 64'(fifo_re), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
        wait_valid("t5_valid", 40);
        check_val("t5_word", 64'(word), 64'hEFBEADDE);
        tick(3);

        // 6: long idle with no partial word
        s_re   = re_cnt;
        s_to   = to_cnt;
        s_busy = busy_cyc;
        tick(1000);
        check_val("t6_no_re", 64'(re_cnt - s_re), 64'd0);
        check_val("t6_no_timeout", 64'(to_cnt - s_to), 64'd0);
        check_val("t6_not_busy", 64'(busy_cyc - s_busy), 64'd0);
        check_val("t6_fifo_re", 64'(fifo_re), 64'd0);

        // Whole-run protocol properties
        check_val("adjacent_re", 64'(adj_cnt), 64'd0);
        check_val("re_while_empty", 64'(bad_re_cnt), 64'd0);
        check_val("word_unstable", 64'(unstable_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
